// File: rtl/mux_pkg.sv
// mux_pkg: shared mode constants and default sizing for mux_n_1_seq
package mux_pkg;
  localparam int DEF_WIDTH = 8;
  localparam int DEF_CHANNELS = 4;
  localparam logic MODE_DIRECT = 1'b0;
  localparam logic MODE_SCAN = 1'b1;
endpackage

// File: rtl/mux_rr_arb.sv
// mux_rr_arb: combinational wrapping first-set search of req starting at ptr
module mux_rr_arb #(
  parameter int CHANNELS = 4,
  localparam int SEL_W = $clog2(CHANNELS)
) (
  input  logic [CHANNELS-1:0] req,
  input  logic [SEL_W-1:0]    ptr,
  output logic [SEL_W-1:0]    gnt,
  output logic                gnt_vld
);
  logic [SEL_W-1:0] idx;
  always_comb begin
    gnt = '0;
    gnt_vld = 1'b0;
    idx = '0;
    for (int i = CHANNELS - 1; i >= 0; i--) begin
      idx = SEL_W'((int'(ptr) + i) % CHANNELS);
      if (req[idx]) begin
        gnt = idx;
        gnt_vld = 1'b1;
      end
    end
  end
endmodule

// File: rtl/mux_n_1_seq.sv
// mux_n_1_seq: registered N:1 mux, direct select or round-robin scan, ready/valid output; MUX_SEL_ERR_EN adds sticky err_out
module mux_n_1_seq
  import mux_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH,
  parameter int CHANNELS = DEF_CHANNELS,
  localparam int SEL_W = $clog2(CHANNELS)
) (
  input  logic                      clk_in,
  input  logic                      rst_n_in,
  input  logic [CHANNELS*WIDTH-1:0] d_in,
  input  logic [CHANNELS-1:0]       valid_in,
  input  logic [SEL_W-1:0]          sel_in,
  input  logic                      mode_in,
  input  logic                      ready_in,
  output logic [WIDTH-1:0]          y_out,
  output logic                      valid_out,
  output logic [SEL_W-1:0]          ch_out
`ifdef MUX_SEL_ERR_EN
  ,
  output logic                      err_out
`endif
);
  localparam int NP = 2 ** SEL_W;
  logic [NP-1:0] v_pad;
  logic [NP*WIDTH-1:0] d_pad;
  logic [WIDTH-1:0] ch_data [NP];
  logic [SEL_W-1:0] ptr, arb_gnt, cand;
  logic arb_vld, dir_ok, cand_vld, load, scan;
  assign v_pad = NP'(valid_in);
  assign d_pad = (NP * WIDTH)'(d_in);
  for (genvar k = 0; k < NP; k++) begin : g_ch
    assign ch_data[k] = d_pad[k*WIDTH +: WIDTH];
  end
  mux_rr_arb #(.CHANNELS(CHANNELS)) u_arb (
    .req(valid_in),
    .ptr(ptr),
    .gnt(arb_gnt),
    .gnt_vld(arb_vld)
  );
  assign scan = mode_in == MODE_SCAN;
  assign dir_ok = v_pad[sel_in];
  assign cand_vld = scan ? arb_vld : dir_ok;
  assign cand = scan ? arb_gnt : sel_in;
  assign load = !valid_out || ready_in;
  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      y_out <= '0;
      ch_out <= '0;
      valid_out <= 1'b0;
      ptr <= '0;
    end else if (load) begin
      valid_out <= cand_vld;
      if (cand_vld) begin
        y_out <= ch_data[cand];
        ch_out <= cand;
      end
      if (cand_vld && scan) ptr <= (cand == SEL_W'(CHANNELS - 1)) ? '0 : cand + 1'b1;
    end
  end
`ifdef MUX_SEL_ERR_EN
  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) err_out <= 1'b0;
    else if (load && !scan && !dir_ok) err_out <= 1'b1;
  end
`endif
endmodule

// File: doc/mux_n_1_seq.md
MUX_N_1_SEQ -- requirements
Module: mux_n_1_seq

Interface
REQ-001 SHALL have parameter WIDTH, default 8, data bits per channel (min 1).
REQ-002 SHALL have parameter CHANNELS, default 4, input channel count (min 2; need not be a power of 2).
REQ-003 SHALL have localparam SEL_W = $clog2(CHANNELS), select/channel index width.
REQ-004 SHALL have port clk_in, input, 1, the single clock; all state changes on its rising edge.
REQ-005 SHALL have port rst_n_in, input, 1, asynchronous active-low reset.
REQ-006 SHALL have port d_in, input, CHANNELS*WIDTH; channel k occupies bits [k*WIDTH +: WIDTH].
REQ-007 SHALL have port valid_in, input, CHANNELS; bit k set means channel k holds data.
REQ-008 SHALL have port sel_in, input, SEL_W; channel index, used in direct mode only.
REQ-009 SHALL have port mode_in, input, 1; 0 = direct select, 1 = round-robin scan.
REQ-010 SHALL have port ready_in, input, 1; downstream accepts y_out.
REQ-011 SHALL have port y_out, output, WIDTH; registered selected data.
REQ-012 SHALL have port valid_out, output, 1; y_out is valid.
REQ-013 SHALL have port ch_out, output, SEL_W; index of the channel held in y_out.

Function
REQ-014 SHALL define load = !valid_out || ready_in; registers update only when load is 1.
REQ-015 SHALL, in direct mode, take sel_in as the candidate when sel_in < CHANNELS and valid_in[sel_in] = 1; otherwise there is no candidate.
REQ-016 SHALL, in scan mode, take as candidate the first set valid_in bit found searching upward from pointer ptr, wrapping from CHANNELS-1 to 0.
REQ-017 SHALL, on load with a candidate g: y_out <= data of g, ch_out <= g, valid_out <= 1.
REQ-018 SHALL, on load with no candidate: valid_out <= 0, y_out and ch_out hold.
REQ-019 SHALL hold y_out, ch_out and valid_out unchanged while valid_out = 1 and ready_in = 0, regardless of d_in, valid_in, sel_in or mode_in.
REQ-020 SHALL update ptr <= (g+1) mod CHANNELS only on a scan-mode load with a grant; ptr holds otherwise, including in direct mode.
REQ-021 SHALL have a latency of exactly one clock from the load edge to valid_out; back-to-back transfers sustain one per clock while ready_in = 1.
REQ-022 SHALL apply a mode_in change at the next load; a stalled word is never replaced.
REQ-023 SHALL have no combinational path from any input to any output.

Reset
REQ-024 SHALL, on rst_n_in low, asynchronously clear y_out = 0, ch_out = 0, valid_out = 0, ptr = 0 (and err_out = 0 if present).
REQ-025 SHALL, when reset is asserted mid-stall, discard the held word; the first post-reset scan starts at channel 0.

Configuration
REQ-026 SHALL, with macro MUX_SEL_ERR_EN defined, add output err_out (1 bit): sticky, set on a direct-mode load when sel_in >= CHANNELS or valid_in[sel_in] = 0, cleared only by reset.
REQ-027 SHALL, without MUX_SEL_ERR_EN, have no err_out port and no related logic; all other behaviour is identical.

Structure
REQ-028 SHALL take from shared package mux_pkg: the mode constants MODE_DIRECT = 1'b0 and MODE_SCAN = 1'b1, plus default values for WIDTH and CHANNELS.
REQ-029 SHALL place the wrapping first-set search in sub-module mux_rr_arb (inputs: request vector, ptr; outputs: grant index, grant-valid); it is purely combinational.

Verification
REQ-030 SHALL cover direct mode: CHANNELS=4, WIDTH=8, d_in ch2=0xA5, valid_in=4'b0100, sel_in=2, ready_in=1 -> next cycle y_out=0xA5, ch_out=2, valid_out=1.
REQ-031 SHALL cover a stall: valid_out=1 with ready_in=0 for 3 cycles while d_in and sel_in change -> y_out and ch_out unchanged; releasing ready_in loads new data on the next edge.
REQ-032 SHALL cover scan wrap: mode_in=1, valid_in=4'b1011, ready_in=1 from reset -> ch_out sequence 0,1,3,0,1.
REQ-033 SHALL cover a non-power-of-2 config with MUX_SEL_ERR_EN: CHANNELS=5, direct mode, sel_in=6 -> valid_out=0 and err_out=1 held until reset.
REQ-034 SHALL cover reset mid-stall: rst_n_in low during a stall -> all outputs 0 immediately (async); in scan mode with all valid, the first grant after release is ch 0.
